// File: rtl/model_convolutional_lstm_matrix_receiver_if.sv
// Element-serial matrix load bus plus registered buffer read port.
// The driver/controller side holds master and the receiver holds slave.
interface model_convolutional_lstm_matrix_receiver_if #(
  parameter int DATA_SIZE  = 64,
  parameter int SIZE_L_MAX = 8,
  parameter int SIZE_X_MAX = 8
);
  localparam int LW = $clog2(SIZE_L_MAX);
  localparam int XW = $clog2(SIZE_X_MAX);

  logic                 START;
  logic                 READY;
  logic                 ERROR;
  logic [DATA_SIZE-1:0] SIZE_L_IN;
  logic [DATA_SIZE-1:0] SIZE_X_IN;
  logic                 DATA_IN_L_ENABLE;
  logic                 DATA_IN_X_ENABLE;
  logic [DATA_SIZE-1:0] DATA_IN;
  logic                 DATA_OUT_L_ENABLE;
  logic                 DATA_OUT_X_ENABLE;
  logic                 RD_ENABLE;
  logic [LW-1:0]        RD_L;
  logic [XW-1:0]        RD_X;
  logic [DATA_SIZE-1:0] RD_DATA;
  logic                 RD_VALID;

  modport master (
    output START, SIZE_L_IN, SIZE_X_IN,
    output DATA_IN_L_ENABLE, DATA_IN_X_ENABLE, DATA_IN,
    output RD_ENABLE, RD_L, RD_X,
    input  READY, ERROR, DATA_OUT_L_ENABLE, DATA_OUT_X_ENABLE,
    input  RD_DATA, RD_VALID
  );

  modport slave (
    input  START, SIZE_L_IN, SIZE_X_IN,
    input  DATA_IN_L_ENABLE, DATA_IN_X_ENABLE, DATA_IN,
    input  RD_ENABLE, RD_L, RD_X,
    output READY, ERROR, DATA_OUT_L_ENABLE, DATA_OUT_X_ENABLE,
    output RD_DATA, RD_VALID
  );
endinterface

// File: rtl/model_convolutional_lstm_matrix_receiver.sv
// Matrix load responder: requests rows/elements with one-cycle strobes and fills an L x X buffer.
// Read port latency 1; driver may answer a request in the same cycle or any later cycle.
module model_convolutional_lstm_matrix_receiver #(
  parameter int DATA_SIZE  = 64,
  parameter int SIZE_L_MAX = 8,
  parameter int SIZE_X_MAX = 8
) (
  input logic CLK,
  input logic RST,
  model_convolutional_lstm_matrix_receiver_if.slave bus
);
  localparam int LW = $clog2(SIZE_L_MAX);
  localparam int XW = $clog2(SIZE_X_MAX);

  localparam logic [1:0] STARTER = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] ENDER   = 2'd2;

  logic [1:0]           state;
  logic [LW-1:0]        l_idx;
  logic [XW-1:0]        x_idx;
  logic [LW:0]          size_l;
  logic [XW:0]          size_x;
  logic                 ready;
  logic                 error;
  logic                 out_l;
  logic                 out_x;
  logic [DATA_SIZE-1:0] rd_data;
  logic                 rd_valid;
  logic [DATA_SIZE-1:0] mem [SIZE_L_MAX*SIZE_X_MAX];

  logic size_ok;
  logic accept_start;
  logic accept_elem;
  logic last_x;
  logic last_l;
  logic rd_in_range;

  // Full-width range check first; only then are the low bits trusted as a size.
  assign size_ok = (bus.SIZE_L_IN != '0) && (bus.SIZE_L_IN <= DATA_SIZE'(SIZE_L_MAX)) &&
                   (bus.SIZE_X_IN != '0) && (bus.SIZE_X_IN <= DATA_SIZE'(SIZE_X_MAX));
  assign accept_start = (state == STARTER || state == ENDER) && ready && bus.START && size_ok;
  assign accept_elem  = (state == WAIT) && bus.DATA_IN_X_ENABLE;
  assign last_x       = ({1'b0, x_idx} == size_x - (XW+1)'(1));
  assign last_l       = ({1'b0, l_idx} == size_l - (LW+1)'(1));
  assign rd_in_range  = ({1'b0, bus.RD_L} < size_l) && ({1'b0, bus.RD_X} < size_x);

  // Buffer and latched sizes deliberately survive reset so a partial load stays readable.
  always_ff @(posedge CLK) begin
    if (accept_start) begin
      size_l <= bus.SIZE_L_IN[LW:0];
      size_x <= bus.SIZE_X_IN[XW:0];
    end
    if (accept_elem) begin
      mem[{l_idx, x_idx}] <= bus.DATA_IN;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= STARTER;
      l_idx <= '0;
      x_idx <= '0;
      ready <= 1'b0;
      error <= 1'b0;
      out_l <= 1'b0;
      out_x <= 1'b0;
    end else begin
      out_l <= 1'b0;
      out_x <= 1'b0;
      case (state)
        STARTER, ENDER: begin
          state <= STARTER;
          ready <= 1'b1;
          if (ready && bus.START) begin
            if (size_ok) begin
              l_idx <= '0;
              x_idx <= '0;
              error <= 1'b0;
              ready <= 1'b0;
              out_l <= 1'b1;
              out_x <= 1'b1;
              state <= WAIT;
            end else begin
              error <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (bus.DATA_IN_X_ENABLE) begin
            if (bus.DATA_IN_L_ENABLE != (x_idx == '0)) begin
              error <= 1'b1;
            end
            if (!last_x) begin
              x_idx <= x_idx + XW'(1);
              out_x <= 1'b1;
            end else if (!last_l) begin
              x_idx <= '0;
              l_idx <= l_idx + LW'(1);
              out_l <= 1'b1;
              out_x <= 1'b1;
            end else begin
              ready <= 1'b1;
              state <= ENDER;
            end
          end
        end
        default: state <= STARTER;
      endcase
    end
  end

  // A same-cycle write is non-blocking, so the read sees the old contents.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= bus.RD_ENABLE;
      if (bus.RD_ENABLE) begin
        rd_data <= rd_in_range ? mem[{bus.RD_L, bus.RD_X}] : '0;
      end
    end
  end

  assign bus.READY             = ready;
  assign bus.ERROR             = error;
  assign bus.DATA_OUT_L_ENABLE = out_l;
  assign bus.DATA_OUT_X_ENABLE = out_x;
  assign bus.RD_DATA           = rd_data;
  assign bus.RD_VALID          = rd_valid;
endmodule

// File: doc/model_convolutional_lstm_matrix_receiver.md
Name: model_convolutional_lstm_matrix_receiver

Overview:
- Responder end of the element-serial matrix load protocol used by the convolutional LSTM bench and controller.
- Takes a START plus L/X sizes, then requests one row at a time with the *_OUT_L_ENABLE / *_OUT_X_ENABLE strobes.
- Accepts each element on the *_IN_L_ENABLE / *_IN_X_ENABLE strobes and stores it in an internal SIZE_L_MAX x SIZE_X_MAX buffer.
- The LSTM datapath reads the buffer back through a registered random-access port (W, K, U and B weight loading).

Parameters:
- DATA_SIZE, 64, element and size-bus width.
- SIZE_L_MAX, 8, maximum rows; must be a power of two.
- SIZE_X_MAX, 8, maximum columns; must be a power of two.

Ports:
- CLK  in  1  single clock; everything samples on the rising edge.
- RST  in  1  reset, asynchronous, active-low.
- START  in  1  one-cycle load request; honoured only when READY=1.
- READY  out  1  high when idle and the buffer is stable.
- ERROR  out  1  sticky protocol/size error; cleared on the next accepted START.
- SIZE_L_IN  in  DATA_SIZE  row count, sampled on START.
- SIZE_X_IN  in  DATA_SIZE  column count, sampled on START.
- DATA_IN_L_ENABLE  in  1  driver marks the first element of a row.
- DATA_IN_X_ENABLE  in  1  driver presents one element on DATA_IN.
- DATA_IN  in  DATA_SIZE  element value.
- DATA_OUT_L_ENABLE  out  1  one-cycle pulse requesting a new row.
- DATA_OUT_X_ENABLE  out  1  one-cycle pulse requesting the next element.
- RD_ENABLE  in  1  buffer read strobe.
- RD_L  in  clog2(SIZE_L_MAX)  read row.
- RD_X  in  clog2(SIZE_X_MAX)  read column.
- RD_DATA  out  DATA_SIZE  read result.
- RD_VALID  out  1  RD_DATA valid pulse.

Behaviour:
- Reset (RST=0, asynchronous):
  - READY=0, ERROR=0, DATA_OUT_L_ENABLE=0, DATA_OUT_X_ENABLE=0, RD_DATA=0, RD_VALID=0.
  - Indices cleared; FSM goes to STARTER.
  - Buffer contents are not cleared.
- FSM STARTER (idle):
  - READY=1.
  - On START with 1<=SIZE_L_IN<=SIZE_L_MAX and 1<=SIZE_X_IN<=SIZE_X_MAX: latch sizes, set l=x=0, clear ERROR, drive READY=0, DATA_OUT_L_ENABLE=1 and DATA_OUT_X_ENABLE=1 for exactly the next cycle, then go to WAIT.
  - On START with an out-of-range size (including 0): ERROR=1, READY stays 1, no strobes issued.
- FSM WAIT:
  - All strobes low; wait indefinitely for DATA_IN_X_ENABLE=1.
  - On acceptance, write DATA_IN to buf[l][x].
  - Check that DATA_IN_L_ENABLE==(x==0); on mismatch set ERROR=1 but still store the element and continue.
  - Then:
    - If x<size_x-1: x++, pulse DATA_OUT_X_ENABLE next cycle.
    - Else if l<size_l-1: x=0, l++, pulse DATA_OUT_L_ENABLE and DATA_OUT_X_ENABLE together next cycle.
    - Else go to ENDER.
  - DATA_IN_L_ENABLE without DATA_IN_X_ENABLE is ignored.
- FSM ENDER: READY=1 in the cycle after the last element is accepted; go to STARTER.
- Throughput:
  - At most one element per cycle.
  - The driver may answer in the same cycle a request pulse is high or any cycle later.
  - An element arriving in the cycle the pulse is high is accepted. A minimum 1-element-per-2-cycles pattern is legal.
- START while busy (READY=0) is ignored; it does not set ERROR and does not restart.
- Reset mid-load: the FSM aborts immediately; rows already written stay in the buffer, and READY returns only after reset release plus one cycle.
- Read port:
  - Latency 1: RD_ENABLE at cycle n gives RD_DATA/RD_VALID at n+1.
  - RD_VALID is a one-cycle pulse per strobe; back-to-back reads are allowed.
  - Index >= latched size (or >= MAX) returns 0 with RD_VALID=1.
  - A read of the location being written in the same cycle returns the old value.
  - RD_DATA holds its last value when no read is active.
- Sizes use the low clog2(MAX)+1 bits for the index compare after the full-width range check.

Test Plan:
- Reset release, then START with SIZE_L=2, SIZE_X=3, driver replies one cycle after each request with 0x10..0x15 -> request pulses: (L+X) first, X, X, then (L+X), X, X; ERROR=0; READY rises one cycle after 0x15 is accepted; reads (0,0)=0x10, (1,2)=0x15, (1,3)=0 with a 1-cycle RD_VALID each.
- Same-cycle answer: driver returns each element while the request pulse is high, 4x4 load -> 16 elements stored, READY after 16 accepts, no ERROR.
- START with SIZE_X=0 and, separately, SIZE_L=9 (MAX=8) -> ERROR=1, READY stays 1, no OUT strobes; a following valid START clears ERROR.
- DATA_IN_L_ENABLE asserted on x=1 of row 0 in a 1x2 load -> ERROR=1, both elements stored, READY returns normally.
- START pulsed again mid-load -> ignored and sequence unchanged; RST=0 during row 1 -> all outputs at reset values immediately; row 0 data still readable after the next reset release.
- Back-to-back reads of 8 addresses during an idle period -> 8 consecutive RD_VALID pulses with the matching data.
